jamma_joy_serial: RTL
=====================

// Module: jamma_joy_serial
// PURPOSE
//  Serial front-end for the JAMMA joystick shifter (74HC165-style chain, 24 bits per frame).
//  Generates JOY_CLK/JOY_LOAD, samples JOY_DATA and assembles joystick1/joystick2.
//  Applies frame-level debounce and presents both words atomically.
//  Sits between the board pins and the top level; feeds I_JOYSTICK_A/B, I_COIN, I_PLAYER and the reset/reboot logic.
// PARAMETERS
//  DIV_W          5   JOY_CLK period = 2**DIV_W clk12 cycles; 50% duty.
//  FRAME_SLOTS    26  JOY_CLK periods per frame (slot 0..25).
//  STABLE_FRAMES  2   consecutive identical frames required before outputs update (1 = no debounce).
// PORTS
//  clk12        in   1   system clock, 12 MHz.
//  pll_lckd     in   1   asynchronous active-low reset.
//  JOY_DATA     in   1   serial data from shifter; asynchronous to clk12.
//  JOY_CLK      out  1   shifter clock, registered.
//  JOY_LOAD     out  1   shifter parallel-load, active low, registered.
//  joystick1    out  12  player 1 word, active low.
//  joystick2    out  12  player 2 word, active low.
//  frame_done   out  1   1-cycle pulse when a complete frame has been captured (pre-debounce).
// BEHAVIOUR
//  Reset (pll_lckd=0), asynchronous:
//   div=0, slot=0, JOY_CLK=0, JOY_LOAD=1, shadow/candidate=12'hFFF each, joystick1/2=12'hFFF, frame_done=0, match=0.
//  Divider:
//   div free-runs mod 2**DIV_W; JOY_CLK = div[DIV_W-1] (registered).
//   rise event: div == 2**(DIV_W-1)-1. fall event: div == 2**DIV_W-1.
//  Slot counter:
//   Advances on each rise event; wraps FRAME_SLOTS-1 -> 0.
//   JOY_LOAD = 0 while slot==0, else 1; changes together with JOY_CLK rising.
//  Sampling:
//   JOY_DATA passes through a 2-flop synchronizer.
//   Sampled on fall event (mid-bit) into the shadow bit for the current slot.
//   Slot 1 is discarded. Map (slot:bit):
//    2:p1[8] 3:p1[6] 4:p1[5] 5:p1[4] 6:p1[3] 7:p1[2] 8:p1[1] 9:p1[0]
//    10:p2[8] 11:p2[6] 12..17:p2[5..0] 18:p2[10] 19:p2[11] 20:p2[9] 21:p2[7]
//    22:p1[10] 23:p1[11] 24:p1[9] 25:p1[7]
//  Frame end:
//   On the fall event of slot FRAME_SLOTS-1, the 24-bit shadow is complete.
//   Next cycle: frame_done=1 for 1 cycle, and debounce evaluates the frame.
//  Debounce:
//   frame == candidate -> match = sat_inc(match); else candidate=frame, match=1.
//   When match reaches STABLE_FRAMES, joystick1/2 <= candidate; both words update in the same cycle.
//   match saturates at STABLE_FRAMES and does not wrap.
//   Bit 11 (reset/reboot buttons) uses the same debounce; no glitch shorter than STABLE_FRAMES frames reaches outputs.
//  Latency: pin change -> output = end of the current frame + (STABLE_FRAMES-1) frames + 1 cycle.
//  Reset mid-frame: the partial shadow is dropped and outputs return to 12'hFFF.
//   After reset release: first JOY_LOAD low at slot 0; no output update before STABLE_FRAMES full frames.
//  JOY_DATA held 1 (no board attached): outputs stay 12'hFFF.
// STRUCTURE
//  Shared package joy_pkg:
//   JOY_W=12; bit-index localparams (JOY_FIRE1..JOY_UP=0..5, JOY_START=8, JOY_COIN=9, JOY_RST=11).
//   Slot->bit map as a constant function used by both RTL and bench.
//  One sub-module: joy_debounce (candidate/match/output regs, 24-bit wide), instantiated once.
//  Divider, slot counter, synchronizer and shadow stay in this module.
// TESTING
//  1. Reset release, JOY_DATA=1 -> JOY_CLK period 32 cycles; JOY_LOAD low for exactly slot 0 each 26*32=832 cycles; outputs 12'hFFF.
//  2. Shifter model drives p1=12'hFFE, p2=12'hDFF for 2 frames -> joystick1=FFE, joystick2=DFF one cycle after the 2nd frame_done; never earlier.
//  3. Single-frame glitch on p1[11]=0 between stable all-1 frames -> joystick1 stays 12'hFFF throughout.
//  4. p1 changes value at a slot mid-frame -> joystick1 and joystick2 update in the same cycle, with no torn word.
//  5. pll_lckd pulsed low at slot 13 after outputs hold FFE -> immediate 12'hFFF, JOY_LOAD=1, JOY_CLK=0; recapture only after 2 full frames.
//  6. STABLE_FRAMES=1, DIV_W=3 -> outputs follow each frame one cycle after frame_done; JOY_CLK period 8 cycles.

Source files
------------

// File: rtl/joy_pkg.sv
// joy_pkg: shared widths, joystick bit indices and the shift-slot to shadow-bit map
// for the JAMMA joystick serial front-end.
package joy_pkg;

  localparam int JOY_W   = 12;
  localparam int FRAME_W = 2 * JOY_W;

  localparam int JOY_FIRE1 = 0;
  localparam int JOY_FIRE2 = 1;
  localparam int JOY_RIGHT = 2;
  localparam int JOY_LEFT  = 3;
  localparam int JOY_DOWN  = 4;
  localparam int JOY_UP    = 5;
  localparam int JOY_START = 8;
  localparam int JOY_COIN  = 9;
  localparam int JOY_RST   = 11;

  // Returns {valid, shadow index}. The shadow holds player 1 in [11:0] and
  // player 2 in [23:12]; slots 0 and 1 carry nothing useful and map to invalid.
  function automatic logic [5:0] slot_map(input logic [4:0] slot);
    logic [5:0] m;
    m = 6'd0;
    case (slot)
      5'd2:    m = {1'b1, 5'd8};
      5'd3:    m = {1'b1, 5'd6};
      5'd4:    m = {1'b1, 5'd5};
      5'd5:    m = {1'b1, 5'd4};
      5'd6:    m = {1'b1, 5'd3};
      5'd7:    m = {1'b1, 5'd2};
      5'd8:    m = {1'b1, 5'd1};
      5'd9:    m = {1'b1, 5'd0};
      5'd10:   m = {1'b1, 5'd20};
      5'd11:   m = {1'b1, 5'd18};
      5'd12:   m = {1'b1, 5'd17};
      5'd13:   m = {1'b1, 5'd16};
      5'd14:   m = {1'b1, 5'd15};
      5'd15:   m = {1'b1, 5'd14};
      5'd16:   m = {1'b1, 5'd13};
      5'd17:   m = {1'b1, 5'd12};
      5'd18:   m = {1'b1, 5'd22};
      5'd19:   m = {1'b1, 5'd23};
      5'd20:   m = {1'b1, 5'd21};
      5'd21:   m = {1'b1, 5'd19};
      5'd22:   m = {1'b1, 5'd10};
      5'd23:   m = {1'b1, 5'd11};
      5'd24:   m = {1'b1, 5'd9};
      5'd25:   m = {1'b1, 5'd7};
      default: m = 6'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// joy_debounce: frame-level debounce of the captured 24-bit word; both players
// live in one register so they always change in the same cycle.
module joy_debounce
  import joy_pkg::*;
#(
  parameter int W             = FRAME_W,
  parameter int STABLE_FRAMES = 2
) (
  input  logic         clk12,
  input  logic         pll_lckd,
  input  logic         frame_valid,
  input  logic [W-1:0] frame,
  output logic [W-1:0] word
);

  localparam int            MW        = $clog2(STABLE_FRAMES + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_FRAMES);
  localparam logic [MW-1:0] MATCH_ONE = MW'(1);

  logic [W-1:0]  candidate;
  logic [MW-1:0] match;
  logic [MW-1:0] match_next;

  // A repeat of the candidate bumps the saturating run length; anything else starts a new run of one.
  always_comb begin
    match_next = MATCH_ONE;
    if (frame == candidate) begin
      match_next = (match == MATCH_MAX) ? MATCH_MAX : match + MATCH_ONE;
    end
  end

  // Track the candidate run and publish it once it has been seen STABLE_FRAMES times in a row.
  always_ff @(posedge clk12 or negedge pll_lckd) begin
    if (!pll_lckd) begin
      candidate <= '1;
      match     <= '0;
      word      <= '1;
    end else if (frame_valid) begin
      candidate <= frame;
      match     <= match_next;
      if (match_next == MATCH_MAX) begin
        word <= frame;
      end
    end
  end

endmodule

// File: rtl/jamma_joy_serial.sv
// jamma_joy_serial: clocks the 74HC165-style joystick chain, samples JOY_DATA mid-bit
// into a 24-bit shadow and hands each complete frame to the debouncer.
module jamma_joy_serial
  import joy_pkg::*;
#(
  parameter int DIV_W         = 5,
  parameter int FRAME_SLOTS   = 26,
  parameter int STABLE_FRAMES = 2
) (
  input  logic             clk12,
  input  logic             pll_lckd,
  input  logic             JOY_DATA,
  output logic             JOY_CLK,
  output logic             JOY_LOAD,
  output logic [JOY_W-1:0] joystick1,
  output logic [JOY_W-1:0] joystick2,
  output logic             frame_done
);

  localparam logic [DIV_W-1:0] RISE_AT   = {1'b0, {(DIV_W-1){1'b1}}};
  localparam logic [DIV_W-1:0] FALL_AT   = {DIV_W{1'b1}};
  localparam logic [4:0]       LAST_SLOT = 5'(FRAME_SLOTS - 1);

  logic [DIV_W-1:0]   div;
  logic [4:0]         slot;
  logic               primed;
  logic [1:0]         data_sync;
  logic [FRAME_W-1:0] shadow;
  logic [FRAME_W-1:0] joy_word;
  logic               rise_evt;
  logic               fall_evt;
  logic               slot_last;
  logic [5:0]         slot_bit;

  assign rise_evt  = (div == RISE_AT);
  assign fall_evt  = (div == FALL_AT);
  assign slot_last = (slot == LAST_SLOT);
  assign slot_bit  = slot_map(slot);

  // Free-running divider, shifter clock and slot counter; LOAD follows slot 0 on the same rising edge,
  // and primed marks that a real parallel load has happened since reset.
  always_ff @(posedge clk12 or negedge pll_lckd) begin
    if (!pll_lckd) begin
      div      <= '0;
      slot     <= '0;
      JOY_CLK  <= 1'b0;
      JOY_LOAD <= 1'b1;
      primed   <= 1'b0;
    end else begin
      div <= div + 1'b1;
      if (rise_evt) begin
        JOY_CLK  <= 1'b1;
        slot     <= slot_last ? 5'd0 : slot + 5'd1;
        JOY_LOAD <= !slot_last;
        if (slot_last) begin
          primed <= 1'b1;
        end
      end else if (fall_evt) begin
        JOY_CLK <= 1'b0;
      end
    end
  end

  // Two-flop synchronizer for the asynchronous shifter output.
  always_ff @(posedge clk12 or negedge pll_lckd) begin
    if (!pll_lckd) begin
      data_sync <= 2'b11;
    end else begin
      data_sync <= {data_sync[0], JOY_DATA};
    end
  end

  // Capture the mid-bit sample into the shadow and flag the frame once its last slot is in.
  always_ff @(posedge clk12 or negedge pll_lckd) begin
    if (!pll_lckd) begin
      shadow     <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= fall_evt && slot_last && primed;
      if (fall_evt && slot_bit[5]) begin
        shadow[slot_bit[4:0]] <= data_sync[1];
      end
    end
  end

  joy_debounce #(
    .W             (FRAME_W),
    .STABLE_FRAMES (STABLE_FRAMES)
  ) u_debounce (
    .clk12       (clk12),
    .pll_lckd    (pll_lckd),
    .frame_valid (frame_done),
    .frame       (shadow),
    .word        (joy_word)
  );

  assign joystick1 = joy_word[JOY_W-1:0];
  assign joystick2 = joy_word[FRAME_W-1:JOY_W];

endmodule
